// File: rtl/regfile_32x32_if.sv
// ---------------------------------------------------------------------------
// regfile_32x32_if
// Bundles the register file's write port and two read ports.
//   RegWrite       write enable
//   WriteRegister  destination address
//   WriteData      value to store
//   ReadRegister1  read-port-1 address  -> ReadData1 (ALU operandA)
//   ReadRegister2  read-port-2 address  -> ReadData2 (ALU operandB)
// master: the datapath side that drives addresses and write data.
// slave : the register file itself.
// ---------------------------------------------------------------------------
interface regfile_32x32_if #(
    parameter int width = 32,
    parameter int aw    = 5
);
    logic             RegWrite;
    logic [aw-1:0]    WriteRegister;
    logic [width-1:0] WriteData;
    logic [aw-1:0]    ReadRegister1;
    logic [aw-1:0]    ReadRegister2;
    logic [width-1:0] ReadData1;
    logic [width-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_32x32.sv
// ---------------------------------------------------------------------------
// regfile_32x32
// 32 x 32-bit general-purpose register file with one synchronous write port
// and two combinational read ports. Register 0 has no storage and reads zero.
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high clear of r1..r31 (wins over a write)
//   bus    regfile_32x32_if.slave: write port and both read ports
// ---------------------------------------------------------------------------
module regfile_32x32 #(
    parameter int width = 32,
    parameter int depth = 32
) (
    input  logic clk,
    input  logic reset,
    regfile_32x32_if.slave bus
);
    localparam int aw = $clog2(depth);

    // Every read-mux input, including the constant zero for r0.
    logic [width-1:0] word_arr [depth];
    // One-hot write decode; r0 has no enable because it has no storage.
    logic [depth-1:1] write_en;

    assign word_arr[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < depth; gi++) begin : g_reg
            logic [width-1:0] q_reg;

            assign write_en[gi] = bus.RegWrite && (bus.WriteRegister == aw'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (write_en[gi]) begin
                    q_reg <= bus.WriteData;
                end
            end

            assign word_arr[gi] = q_reg;
        end
    endgenerate

    // Reads come straight from the flops: no bypass, so a same-cycle write
    // to the addressed register only shows after the edge.
    assign bus.ReadData1 = word_arr[bus.ReadRegister1];
    assign bus.ReadData2 = word_arr[bus.ReadRegister2];
endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

Thirty-two-entry, 32-bit general-purpose register file that sits directly upstream of the ALU in the Lab 3 CPU datapath. Its two asynchronous read ports drive the ALU's `operandA` and `operandB` inputs. Its single synchronous write port takes the selected writeback value, normally the ALU `result`. Register 0 is hardwired to zero.

## Interface
- `width`, 32: data width of every register and port.
- `depth`, 32: number of registers; fixed at 32 because addresses are 5 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; clears every register on a rising `clk` edge while high.
- `RegWrite`  input  1  write enable.
- `WriteRegister`  input  5  destination register address.
- `WriteData`  input  32  value to write.
- `ReadRegister1`  input  5  read-port-1 address.
- `ReadRegister2`  input  5  read-port-2 address.
- `ReadData1`  output  32  contents of `ReadRegister1`; feeds ALU `operandA`.
- `ReadData2`  output  32  contents of `ReadRegister2`; feeds ALU `operandB`.

## Operation
- Storage: registers r1..r31 are each 32-bit `width` registers built from D flip-flops. Each register has its own enable.
- Write decode:
  - A 5:32 decoder on `WriteRegister` is gated by `RegWrite`.
  - Enable k is high only when `RegWrite`=1 and `WriteRegister`=k.
  - At most one register is written per cycle.
- Register 0:
  - No storage element.
  - Always reads 32'h00000000.
  - Writes to address 0 are silently discarded, whatever `WriteData` is.
- Read:
  - Each port is a 32:1 mux of 32-bit words selected by its address.
  - Purely combinational; no read enable.
  - Both ports may address the same register and both return the same value.
- Reset:
  - While `reset`=1 at a rising edge, r1..r31 load 0.
  - Reset takes priority over any simultaneous write; the write is lost.
  - Reset asserted mid-operation affects only the next edge. Reads between edges still show the pre-reset contents.
- Reset values: all registers hold 0 after reset. `ReadData1` and `ReadData2` therefore read 0 for every address until a write occurs.
- Flags: no ALU flags (`zero`, `carryout`, `overflow`) are stored here. They are consumed elsewhere.

## Timing
- Write latency: 1 cycle. A value presented with `RegWrite`=1 before edge n is visible on a read port after edge n, within the mux propagation delay.
- Same-cycle read and write of one address:
  - The read port returns the old value for the rest of that cycle. There is no write-through bypass.
  - The new value appears after the edge.
- `RegWrite`=0: contents hold indefinitely. `WriteRegister` and `WriteData` are don't-care.
- Setup and hold for `RegWrite`, `WriteRegister`, `WriteData` and `reset` are relative to the rising `clk` edge only. Glitches between edges have no effect.
- Read path is combinational: address-to-data and storage-to-data delays are each one 32:1 mux depth. No added cycles in the datapath.

## Test plan
- Reset then read:
  - Stimulus: assert `reset` for 1 edge, then sweep `ReadRegister1` and `ReadRegister2` over 0..31.
  - Required: both ports read 32'h00000000 for every address.
- Basic write/read:
  - Stimulus: write 32'hDEADBEEF to r5, then 32'h12345678 to r31. Read r5 on port 1 and r31 on port 2.
  - Required: port 1 = DEADBEEF, port 2 = 12345678. Every other address still reads 0.
- Register-0 protection:
  - Stimulus: `RegWrite`=1, `WriteRegister`=0, `WriteData`=32'hFFFFFFFF for one edge. Read address 0 on both ports.
  - Required: both ports read 32'h00000000.
- Decoder isolation and enable:
  - Stimulus: write each register k (1..31) with its own index value. Then assert one edge with `RegWrite`=0, `WriteRegister`=7, `WriteData`=32'hAAAAAAAA.
  - Required: every register k reads back exactly k. r7 still reads 7.
- Read-during-write:
  - Stimulus: r9 holds 32'h00000001. In one cycle, write 32'h00000002 to r9 while reading r9 on both ports.
  - Required: both ports read 1 before the edge and 2 after it.
- Reset-vs-write priority:
  - Stimulus: r3 holds 32'h0000CAFE. Assert `reset`=1 and `RegWrite`=1 with `WriteRegister`=3, `WriteData`=32'h0000BEEF on the same edge.
  - Required: r3 reads 0 after the edge. All registers read 0.
